// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants,
// common to the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DATA_BITS     = 8;
  // Data index whose sample is the last before the stop bit.
  localparam logic [2:0]  LAST_DATA_IDX = 3'(DATA_BITS - 1);

  function automatic int unsigned sample_point(input int unsigned bps_cnt);
    return (bps_cnt / 2) - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a delay flop for
// falling-edge detection, gated until a real high level has been seen.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic       meta_q, sync_q, dly_q;
  logic [1:0] vld_q;
  logic       armed_q;
  logic       armed_d;

  // Reset forces all stages high, so a line held low over reset release
  // must go high before any edge is reported; vld_q tracks real data.
  assign armed_d = armed_q | (vld_q[1] & sync_q);

  // Synchronizer, delay stage and arming state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      dly_q   <= 1'b1;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      meta_q  <= async_i;
      sync_q  <= meta_q;
      dly_q   <= sync_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = armed_q & dly_q & ~sync_q;

endmodule

// File: rtl/uart_recv.sv
// UART receiver, 8N1, mid-bit sampling. Defining UART_RX_FRAME_ERR_EN
// enables stop-bit checking and the Uart_frame_err output.
module uart_recv
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 9600
) (
  input  logic       CLK_SYS,
  input  logic       CLK_RST,
  input  logic       Uart_RXD,
  output logic [7:0] Uart_dout,
  output logic       Uart_RX_done,
  output logic       Uart_RX_busy
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       Uart_frame_err
`endif
);

  localparam int unsigned BPS_CNT    = CLK_FREQ / UART_BPS;
  localparam logic [15:0] CNT_LAST   = 16'(BPS_CNT - 1);
  localparam logic [15:0] CNT_SAMPLE = 16'(sample_point(BPS_CNT));

  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  dout_q, dout_d;
  logic        done_q, done_d;
  logic        busy_q;
  logic        rxd_sync_s, rxd_fall_s;
  logic        sample_s, wrap_s;
`ifdef UART_RX_FRAME_ERR_EN
  logic        ferr_q, ferr_d;
`endif

  uart_rx_sync u_sync (
    .clk_i   (CLK_SYS),
    .rst_ni  (CLK_RST),
    .async_i (Uart_RXD),
    .sync_o  (rxd_sync_s),
    .fall_o  (rxd_fall_s)
  );

  assign sample_s = (cnt_q == CNT_SAMPLE);
  assign wrap_s   = (cnt_q == CNT_LAST);

  // Next-state, bit timing and output decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_d  = 1'b0;
`endif
    if (state_q == ST_IDLE) begin
      cnt_d = 16'd0;
    end else if (wrap_s) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
    case (state_q)
      ST_IDLE: begin
        idx_d = 3'd0;
        if (rxd_fall_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (sample_s && rxd_sync_s) begin
          state_d = ST_IDLE;
        end else if (wrap_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (sample_s) begin
          shift_d[idx_q] = rxd_sync_s;
        end else begin
          shift_d = shift_q;
        end
        if (wrap_s && (idx_q == LAST_DATA_IDX)) begin
          state_d = ST_STOP;
          idx_d   = 3'd0;
        end else if (wrap_s) begin
          idx_d   = idx_q + 3'd1;
        end else begin
          idx_d   = idx_q;
        end
      end
      ST_STOP: begin
        if (sample_s) begin
          state_d = ST_IDLE;
`ifdef UART_RX_FRAME_ERR_EN
          if (rxd_sync_s) begin
            dout_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
`else
          dout_d = shift_q;
          done_d = 1'b1;
`endif
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      dout_q  <= 8'h00;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q  <= ferr_d;
`endif
    end
  end

  assign Uart_dout    = dout_q;
  assign Uart_RX_done = done_q;
  assign Uart_RX_busy = busy_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign Uart_frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv: a serial-line driver feeds frames and a
// queue of expected bytes is checked against every done/error pulse.
module tb_uart_recv;

  localparam int BPS     = 10;
  localparam int NOM     = 100;
  localparam int LATENCY = 9 * BPS + BPS / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] dout;
  logic       done, busy;
`ifdef UART_RX_FRAME_ERR_EN
  logic       ferr;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_dout = 8'h00;
  int         exp_ferr = 0;
  int         cyc = 0;
  int         busy_rise = 0;
  logic       busy_prev = 1'b0;
  int         done_cnt = 0;

  always #5 clk = ~clk;

  uart_recv #(.CLK_FREQ(1000000), .UART_BPS(100000)) dut (
    .CLK_SYS      (clk),
    .CLK_RST      (rst_n),
    .Uart_RXD     (rxd),
    .Uart_dout    (dout),
    .Uart_RX_done (done),
    .Uart_RX_busy (busy)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .Uart_frame_err (ferr)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Compare process: every done/error pulse must match the model queue.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        busy_prev = 1'b0;
      end else begin
        if (busy && !busy_prev) busy_rise = cyc;
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            chk("done_unexpected", done, 1'b0);
          end else begin
            model_dout = exp_q.pop_front();
            chk("dout_at_done", dout, model_dout);
            chk("done_latency", cyc - busy_rise, LATENCY);
          end
        end else begin
          chk("dout_hold", dout, model_dout);
        end
`ifdef UART_RX_FRAME_ERR_EN
        if (ferr) begin
          if (exp_ferr == 0) begin
            chk("ferr_unexpected", ferr, 1'b0);
          end else begin
            exp_ferr--;
            chk("ferr_latency", cyc - busy_rise, LATENCY);
          end
        end
`endif
        busy_prev = busy;
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input int period, input bit stop_ok);
`ifdef UART_RX_FRAME_ERR_EN
    if (stop_ok) exp_q.push_back(b);
    else exp_ferr++;
`else
    exp_q.push_back(b);
`endif
    rxd = 1'b0;
    #(period);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(period);
    end
    rxd = stop_ok;
    #(period);
    rxd = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp_ferr != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < 400, 1'b1);
  endtask

  task automatic align();
    @(posedge clk);
    #3;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    int  saw_busy;
    int  per;
    int  gap;
    logic [7:0] b;
    bit  ok;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", dout, 8'h00);
    chk("reset_done", done, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Single nominal frame
    align();
    send_frame(8'hA5, NOM, 1'b1);
    wait_drain("drain_a5");
    chk("a5_value", dout, 8'hA5);
    chk("a5_busy_after", busy, 1'b0);

    // Bad stop bit
    repeat (5) @(posedge clk);
    align();
    send_frame(8'h3C, NOM, 1'b0);
    #(NOM);
    wait_drain("drain_3c");
`ifdef UART_RX_FRAME_ERR_EN
    chk("ferr_keeps_a5", dout, 8'hA5);
`else
    chk("nocheck_3c", dout, 8'h3C);
`endif

    // Back-to-back frames
    base = done_cnt;
    align();
    send_frame(8'h00, NOM, 1'b1);
    send_frame(8'hFF, NOM, 1'b1);
    send_frame(8'h55, NOM, 1'b1);
    wait_drain("drain_b2b");
    chk("b2b_count", done_cnt - base, 3);
    chk("b2b_last", dout, 8'h55);

    // Three-cycle glitch: false start
    base = done_cnt;
    saw_busy = 0;
    repeat (5) @(posedge clk);
    align();
    rxd = 1'b0;
    #30;
    rxd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    chk("glitch_busy_seen", saw_busy, 1);
    chk("glitch_busy_low", busy, 1'b0);
    chk("glitch_no_done", done_cnt - base, 0);
    chk("glitch_dout", dout, 8'h55);

    // Reset during bit 4 of 8'hC3, line held low across release
    align();
    rxd = 1'b0;
    #(NOM);
    b = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      #(NOM);
    end
    rxd = 1'b0;
    #(NOM / 2);
    rst_n = 1'b0;
    #1;
    chk("midreset_dout", dout, 8'h00);
    chk("midreset_done", done, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    exp_q.delete();
    model_dout = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    base = done_cnt;
    saw_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    chk("low_release_no_busy", saw_busy, 0);
    rxd = 1'b1;
    repeat (5) @(posedge clk);
    align();
    send_frame(8'h12, NOM, 1'b1);
    wait_drain("drain_12");
    chk("fresh_12", dout, 8'h12);
    chk("fresh_12_count", done_cnt - base, 1);

    // Baud mismatch +2% and -2%
    align();
    send_frame(8'h96, 98, 1'b1);
    wait_drain("drain_96_fast");
    chk("fast_96", dout, 8'h96);
    repeat (3) @(posedge clk);
    align();
    send_frame(8'h96, 102, 1'b1);
    wait_drain("drain_96_slow");
    chk("slow_96", dout, 8'h96);

    // Randomized frames, rates, gaps and stop bits
    for (int k = 0; k < 16; k++) begin
      b   = 8'($urandom_range(0, 255));
      per = 98 + 2 * $urandom_range(0, 2);
      ok  = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(3, 20);
      send_frame(b, per, ok);
      if (!ok) #(per);
      #(gap * 10);
    end
    wait_drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter UART_BPS, default 9600, meaning serial baud rate; BPS_CNT = CLK_FREQ / UART_BPS clocks per bit.
REQ-003 The block SHALL have port CLK_SYS, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port CLK_RST, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port Uart_RXD, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port Uart_dout, output, 8 bits: last correctly received byte.
REQ-007 The block SHALL have port Uart_RX_done, output, 1 bit: one-cycle pulse, Uart_dout newly valid.
REQ-008 The block SHALL have port Uart_RX_busy, output, 1 bit: high while a frame is being received.
REQ-009 The block SHALL have port Uart_frame_err, output, 1 bit: one-cycle pulse on bad stop bit (present only per REQ-027).

Function
REQ-010 Uart_RXD SHALL pass through a 2-flop synchronizer, plus a third flop for falling-edge detect (sync_d1 low, sync_d2 high).
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; Uart_RX_busy = (state != IDLE).
REQ-013 IDLE -> START on synchronized falling edge; cnt_sys (16 bits) and bit index (3 bits) cleared in that cycle.
REQ-014 In START/DATA/STOP, cnt_sys SHALL count 0..BPS_CNT-1 and wrap to 0; the sample point is cnt_sys == BPS_CNT/2 - 1.
REQ-015 START: at sample point, synchronized line high -> false start, return to IDLE with no done or error pulse; low -> DATA at next wrap.
REQ-016 DATA: at each sample point, shift line into bit[index]; after index 7 sample, go to STOP at next wrap; index wraps 7->0 only via state change.
REQ-017 STOP: at sample point, line high -> Uart_dout loaded with shift register, Uart_RX_done pulsed the same cycle, state -> IDLE next cycle.
REQ-018 Return to IDLE at mid-stop-bit SHALL allow a back-to-back frame's start edge to be detected with no lost frames at +/-2% baud mismatch.
REQ-019 Latency: Uart_RX_done SHALL assert 9*BPS_CNT + BPS_CNT/2 cycles after the edge-detect cycle (+/-0).
REQ-020 Uart_dout SHALL hold its value until the next successful frame; it SHALL NOT change on false start or frame error.
REQ-021 Falling edges seen while not IDLE SHALL be ignored.

Reset
REQ-022 On CLK_RST low, asynchronously: state IDLE, counters 0, synchronizer flops 1, Uart_dout 8'h00, Uart_RX_done 0, Uart_RX_busy 0, Uart_frame_err 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame; after release, a line already low SHALL NOT be taken as a start edge until it goes high then low.

Configuration
REQ-024 Macro UART_RX_FRAME_ERR_EN SHALL select stop-bit checking.
REQ-025 With UART_RX_FRAME_ERR_EN defined: stop sample low -> Uart_frame_err pulses one cycle, no Uart_RX_done, Uart_dout unchanged, state -> IDLE.
REQ-026 Without it: stop bit not checked, Uart_RX_done always pulses at stop sample point.
REQ-027 Uart_frame_err port SHALL exist only when UART_RX_FRAME_ERR_EN is defined.

Structure
REQ-028 Shared package uart_pkg SHALL hold FSM state encodings and frame constants (data bits 8, stop sample index), shared with the transmitter.
REQ-029 Synchronizer and edge detect SHALL be sub-module uart_rx_sync (ports: clock, reset, async in, synced out, fall pulse).

Verification (CLK_FREQ=1000000, UART_BPS=100000, BPS_CNT=10)
REQ-030 Send 8'hA5 at nominal baud -> one Uart_RX_done pulse 95 cycles after edge detect, Uart_dout=8'hA5, busy low afterwards.
REQ-031 Back-to-back 8'h00, 8'hFF, 8'h55 with one stop bit each -> three done pulses, values in order.
REQ-032 Low glitch of 3 cycles on idle line -> busy high then low, no done, Uart_dout unchanged.
REQ-033 With UART_RX_FRAME_ERR_EN, send 8'h3C with stop bit 0 -> Uart_frame_err one pulse, no done, Uart_dout keeps prior 8'hA5.
REQ-034 Assert CLK_RST during bit 4 of 8'hC3, hold line low over release -> all outputs reset values, no done until a fresh 8'h12 frame is received correctly.
REQ-035 Send 8'h96 at baud +2% and -2% -> Uart_dout=8'h96 each time.
